// File: rtl/sar_adc_seq.sv
// Multi-channel SAR ADC conversion sequencer: sample/hold, MSB-first successive
// approximation from a 1-bit comparator, tagged result with one-cycle valid strobe.
module sar_adc_seq #(
  parameter int unsigned NOB           = 8,
  parameter int unsigned NCH           = 4,
  parameter int unsigned CHW           = 2,
  parameter int unsigned SAMPLE_CYCLES = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic           mode,
  input  logic           stop,
  input  logic [CHW-1:0] ch_sel,
  input  logic           cmp,
  output logic           sample,
  output logic [CHW-1:0] ch,
  output logic [NOB-1:0] value,
  output logic [NOB-1:0] result,
  output logic [CHW-1:0] result_ch,
  output logic           valid,
  output logic           busy
);

  localparam int unsigned CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IW      = $clog2(NOB);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [IW-1:0]  idx, idx_n;
  logic [NOB-1:0] code, code_n;
  logic           scan, scan_n;
  logic           stop_l, stop_n;

  logic           sample_n, valid_n, busy_n;
  logic [CHW-1:0] ch_n, result_ch_n;
  logic [NOB-1:0] value_n, result_n;
  logic [NOB-1:0] trial, kept;

  // Next state and next registered outputs
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    idx_n       = idx;
    code_n      = code;
    scan_n      = scan;
    stop_n      = stop_l | stop;
    sample_n    = 1'b0;
    ch_n        = ch;
    value_n     = '0;
    result_n    = result;
    result_ch_n = result_ch;
    valid_n     = 1'b0;
    busy_n      = 1'b1;
    trial       = code | (NOB'(1) << idx);
    kept        = cmp ? trial : code;

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        stop_n = 1'b0;
        if (go) begin
          scan_n   = mode;
          ch_n     = (int'(ch_sel) < int'(NCH)) ? ch_sel : '0;
          cnt_n    = '0;
          sample_n = 1'b1;
          busy_n   = 1'b1;
          state_n  = SAMPLE;
        end
      end
      SAMPLE: begin
        sample_n = 1'b1;
        if (cnt == CW'(SAMPLE_CYCLES - 1)) begin
          sample_n = 1'b0;
          cnt_n    = '0;
          idx_n    = IW'(NOB - 1);
          code_n   = '0;
          value_n  = NOB'(1) << (NOB - 1);
          state_n  = CONV;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      CONV: begin
        value_n = trial;
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          // Comparator only trusted on the final settle cycle of each slot
          cnt_n  = '0;
          code_n = kept;
          if (idx == '0) begin
            value_n     = '0;
            valid_n     = 1'b1;
            result_n    = kept;
            result_ch_n = ch;
            state_n     = DONE;
          end else begin
            idx_n   = idx - IW'(1);
            value_n = kept | (NOB'(1) << (idx - IW'(1)));
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DONE: begin
        if (!scan || stop_l || stop) begin
          busy_n  = 1'b0;
          scan_n  = 1'b0;
          stop_n  = 1'b0;
          state_n = IDLE;
        end else begin
          ch_n     = (ch == CHW'(NCH - 1)) ? '0 : ch + CHW'(1);
          cnt_n    = '0;
          sample_n = 1'b1;
          state_n  = SAMPLE;
        end
      end
      default: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      code      <= '0;
      scan      <= 1'b0;
      stop_l    <= 1'b0;
      sample    <= 1'b0;
      ch        <= '0;
      value     <= '0;
      result    <= '0;
      result_ch <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      code      <= code_n;
      scan      <= scan_n;
      stop_l    <= stop_n;
      sample    <= sample_n;
      ch        <= ch_n;
      value     <= value_n;
      result    <= result_n;
      result_ch <= result_ch_n;
      valid     <= valid_n;
      busy      <= busy_n;
    end
  end

endmodule
